seg7_mux_driver: RTL

Parametrised, time-multiplexed seven-segment display driver. It scans `NUM_DIGITS` hexadecimal digits onto a shared cathode bus with per-digit anode select, per-digit decimal points, optional leading-zero blanking and an anti-ghosting blank interval. It sits between any debug source, such as CPU address/data bus taps, and the board display pins. It replaces the fixed single-digit, fixed-anode encoder.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/scan_prescaler.sv | 50 +++++
 rtl/seg7_mux_driver.sv | 103 ++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: hex glyph table, segment bit positions and the encoder.
package seg7_pkg;

  localparam int unsigned SEG_A_BIT  = 7;
  localparam int unsigned SEG_G_BIT  = 1;
  localparam int unsigned SEG_DP_BIT = 0;

  // Active-high sense: every segment dark.
  localparam logic [7:0] SEG_OFF = 8'h00;

  // Active-high {a,b,c,d,e,f,g}; element 15 written first.
  localparam logic [15:0][6:0] HEX_TABLE = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  function automatic logic [7:0] seg7_encode(input logic [3:0] nibble, input logic dp,
                                             input logic active_low);
    logic [7:0] seg_ah;
    seg_ah = SEG_OFF;
    seg_ah[SEG_A_BIT -: 7] = HEX_TABLE[nibble];
    seg_ah[SEG_DP_BIT] = dp;
    return active_low ? ~seg_ah : seg_ah;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Dwell timer and digit scanner: counts DIV cycles per digit and flags each completed frame.
module scan_prescaler #(
  parameter int unsigned DIV        = 10,
  parameter int unsigned NUM_DIGITS = 4,
  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1,
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic            clk_in,
  input  logic            reset,
  output logic [CntW-1:0] cnt_o,
  output logic [IdxW-1:0] digit_idx_o,
  output logic            frame_tick_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    idx_d  = idx_q;
    tick_d = 1'b0;
    if (cnt_q == CntW'(DIV - 1)) begin
      cnt_d = '0;
      if (idx_q == IdxW'(NUM_DIGITS - 1)) begin
        idx_d  = '0;
        tick_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      tick_q <= tick_d;
    end
  end

  assign cnt_o        = cnt_q;
  assign digit_idx_o  = idx_q;
  assign frame_tick_o = tick_q;

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed hex display driver: shadowed digit data, leading-zero blanking and an
// all-anodes-off interval at the start of every dwell to suppress ghosting.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned DIGIT_HZ       = 1000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lzb_en,
  input  logic                    load,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [IdxW-1:0]         digit_idx,
  output logic                    frame_tick
);

  localparam int unsigned Div  = CLK_HZ / DIGIT_HZ;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0]       BlankEnd = CntW'(BLANK_CYCLES);
  localparam logic [7:0]            SegIdle  = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] AnIdle   = {NUM_DIGITS{AN_ACTIVE_LOW}};

  if (Div < BLANK_CYCLES + 2) begin : gen_div_check
    $error("seg7_mux_driver: dwell too short for the blank interval");
  end

  logic [CntW-1:0]         cnt;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic                    lzb_q;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  scan_prescaler #(
    .DIV        (Div),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_scan_prescaler (
    .clk_in       (clk_in),
    .reset        (reset),
    .cnt_o        (cnt),
    .digit_idx_o  (digit_idx),
    .frame_tick_o (frame_tick)
  );

  always_comb begin
    logic       zero_above;
    logic [3:0] nib;
    logic       dp;
    logic       blank;
    logic       in_blank;
    zero_above = 1'b1;
    nib        = '0;
    dp         = 1'b0;
    blank      = 1'b0;
    in_blank   = (cnt < BlankEnd);
    an_d       = AnIdle;
    // Walk from the most significant digit so zero_above covers nibbles i..NUM_DIGITS-1.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (value_q[4*i +: 4] == 4'h0);
      if (digit_idx == IdxW'(i)) begin
        nib   = value_q[4*i +: 4];
        dp    = dp_q[i];
        blank = lzb_q && (i != 0) && zero_above;
      end
      an_d[i] = AN_ACTIVE_LOW ^ ((digit_idx == IdxW'(i)) && !in_blank);
    end
    seg_d = seg7_encode(nib, dp, SEG_ACTIVE_LOW);
    if (blank) begin
      seg_d[SEG_A_BIT:SEG_G_BIT] = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      dp_q    <= '0;
      lzb_q   <= 1'b0;
      seg_q   <= SegIdle;
      an_q    <= AnIdle;
    end else begin
      if (load) begin
        value_q <= value;
        dp_q    <= dp_in;
        lzb_q   <= lzb_en;
      end
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg_out = seg_q;
  assign an_out  = an_q;

endmodule
